wish_master: RTL and testbench

Wishbone bus master bridging the multicycle RISC-V core's memory-stage request signals onto the Wishbone bus that feeds the memory-controller slave. Accepts one read or write request from the core's control FSM and drives a classic single-beat Wishbone cycle (cyc/stb/we/ADR/DAT). Waits for the slave's ack, returns read data and a one-cycle completion pulse to the core. Aborts with an error pulse if no ack arrives within a bounded number of cycles.

---
 rtl/wish_pkg.sv | 14 +
 rtl/wish_master_if.sv | 31 +++
 rtl/wish_master.sv | 117 +++++++++++
 tb/tb_wish_master.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/wish_pkg.sv
// rtl/wish_pkg.sv - shared Wishbone master/slave types and default widths
package wish_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } wish_state_e;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/wish_master_if.sv
// rtl/wish_master_if.sv - core request side and Wishbone bus side of the master
interface wish_master_if #(
  parameter int ADDR_W = wish_pkg::DEF_ADDR_W,
  parameter int DATA_W = wish_pkg::DEF_DATA_W
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_err;
  logic              cpu_busy;
  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] ADR_O;
  logic [DATA_W-1:0] DAT_O;
  logic [DATA_W-1:0] DAT_I;
  logic              ack;

  modport master (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, DAT_I, ack,
    output cpu_rdata, cpu_done, cpu_err, cpu_busy, cyc, stb, we, ADR_O, DAT_O
  );

  modport slave (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, DAT_I, ack,
    input  cpu_rdata, cpu_done, cpu_err, cpu_busy, cyc, stb, we, ADR_O, DAT_O
  );
endinterface

// File: rtl/wish_master.sv
// rtl/wish_master.sv - single-beat Wishbone master for core memory requests
module wish_master
  import wish_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  wish_master_if.master bus
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  wish_state_e       r_state, w_state;
  logic              r_cyc, w_cyc;
  logic              r_stb, w_stb;
  logic              r_we, w_we;
  logic [ADDR_W-1:0] r_adr, w_adr;
  logic [DATA_W-1:0] r_dat, w_dat;
  logic [DATA_W-1:0] r_rdata, w_rdata;
  logic              r_done, w_done;
  logic              r_err, w_err;
  logic              r_busy, w_busy;
  logic [CNT_W-1:0]  r_cnt, w_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_cyc   <= w_cyc;
      r_stb   <= w_stb;
      r_we    <= w_we;
      r_adr   <= w_adr;
      r_dat   <= w_dat;
      r_rdata <= w_rdata;
      r_done  <= w_done;
      r_err   <= w_err;
      r_busy  <= w_busy;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cyc   = r_cyc;
    w_stb   = r_stb;
    w_we    = r_we;
    w_adr   = r_adr;
    w_dat   = r_dat;
    w_rdata = r_rdata;
    w_cnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.cpu_rd && bus.cpu_wr) begin
          w_state = ERR;
        end else if (bus.cpu_rd || bus.cpu_wr) begin
          w_state = REQ;
          w_cyc   = 1'b1;
          w_stb   = 1'b1;
          w_we    = bus.cpu_wr;
          w_adr   = bus.cpu_addr;
          w_dat   = bus.cpu_wdata;
          w_cnt   = '0;
        end
      end
      REQ: begin
        // ack is checked before the timeout so a last-cycle ack still completes
        if (bus.ack) begin
          w_cyc   = 1'b0;
          w_stb   = 1'b0;
          w_we    = 1'b0;
          w_state = DONE;
          if (!r_we) w_rdata = bus.DAT_I;
        end else if (r_cnt == CNT_LAST) begin
          w_cyc   = 1'b0;
          w_stb   = 1'b0;
          w_we    = 1'b0;
          w_state = ERR;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      DONE:    w_state = IDLE;
      ERR:     w_state = IDLE;
      default: w_state = IDLE;
    endcase
    // Pulses and busy are registered from the next state so they line up with it
    w_done = (w_state == DONE);
    w_err  = (w_state == ERR);
    w_busy = (w_state != IDLE);
  end

  assign bus.cyc       = r_cyc;
  assign bus.stb       = r_stb;
  assign bus.we        = r_we;
  assign bus.ADR_O     = r_adr;
  assign bus.DAT_O     = r_dat;
  assign bus.cpu_rdata = r_rdata;
  assign bus.cpu_done  = r_done;
  assign bus.cpu_err   = r_err;
  assign bus.cpu_busy  = r_busy;

endmodule

// File: tb/tb_wish_master.sv
// tb/tb_wish_master.sv - transaction-level checks of wish_master against a reference model
module tb_wish_master;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wish_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  wish_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] exp_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 read, 1 write, 2 both; waits >= TIMEOUT means the slave never acks
  task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdval, input int waits, input string tag);
    int n_stb   = 0;
    int n_cyc   = 0;
    bit seen    = 0;
    bit got_d   = 0;
    bit got_e   = 0;
    bit stable  = 1;
    bit busy_ok = 1;
    bit exp_done;
    int exp_stb;
    exp_done = (kind != 2) && (waits < TIMEOUT);
    exp_stb  = (kind == 2) ? 0 : ((waits < TIMEOUT) ? waits + 1 : TIMEOUT);
    bus.cpu_rd    = (kind != 1);
    bus.cpu_wr    = (kind != 0);
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    for (int c = 0; c < TIMEOUT + 8; c++) begin
      tick();
      n_cyc++;
      if (bus.cpu_done || bus.cpu_err) begin
        seen  = 1;
        got_d = bus.cpu_done;
        got_e = bus.cpu_err;
        break;
      end
      if (!bus.cpu_busy) busy_ok = 0;
      if (bus.stb) begin
        n_stb++;
        if (!bus.cyc || bus.ADR_O !== addr || bus.we !== (kind == 1) ||
            (kind == 1 && bus.DAT_O !== wdata)) stable = 0;
        bus.ack   = (n_stb == waits + 1);
        bus.DAT_I = bus.ack ? rdval : $urandom;
      end else begin
        bus.ack = 1'b0;
      end
    end
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
    bus.ack    = 1'b0;
    if (exp_done && kind == 0) exp_rdata = rdval;
    chk({tag, "_pulse_seen"}, seen, 1);
    chk({tag, "_done"}, got_d, exp_done);
    chk({tag, "_err"}, got_e, !exp_done);
    chk({tag, "_stb_cycles"}, n_stb, exp_stb);
    chk({tag, "_latency"}, n_cyc, exp_stb + 1);
    chk({tag, "_bus_stable"}, stable, 1);
    chk({tag, "_busy_during"}, busy_ok, 1);
    chk({tag, "_cyc_at_pulse"}, bus.cyc, 0);
    chk({tag, "_rdata"}, bus.cpu_rdata, exp_rdata);
    tick();
    chk({tag, "_post_pulses"}, {bus.cpu_done, bus.cpu_err}, 0);
    chk({tag, "_post_idle"}, {bus.cpu_busy, bus.cyc, bus.stb}, 0);
  endtask

  initial begin
    logic [31:0] a, d, r;
    int          k, w;
    bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.DAT_I = 0; bus.ack = 0;
    reset = 1'b1;
    tick();
    tick();
    chk("reset_ctrl", {bus.cyc, bus.stb, bus.we, bus.cpu_done, bus.cpu_err, bus.cpu_busy}, 0);
    chk("reset_data", {bus.ADR_O, bus.DAT_O}, 0);
    chk("reset_rdata", bus.cpu_rdata, 0);
    reset = 1'b0;
    tick();

    run_txn(0, 32'h04, 32'h0, 32'hAA, 0, "rd_zero_wait");
    run_txn(1, 32'h08, 32'hAB, 32'h55, 2, "wr_two_waits");
    run_txn(0, 32'h20, 32'h0, 32'h77, TIMEOUT, "rd_timeout");
    run_txn(2, 32'h24, 32'h1, 32'h66, 0, "rd_wr_both");
    run_txn(0, 32'h28, 32'h0, 32'h1234, TIMEOUT - 1, "ack_at_timeout");
    run_txn(0, 32'h10, 32'h0, 32'hBEEF, 0, "held_first");
    run_txn(0, 32'h0C, 32'h0, 32'hCAFE, 1, "held_second");

    bus.ack = 1'b1;
    bus.DAT_I = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray_ack_ignored", {bus.cyc, bus.cpu_done, bus.cpu_err, bus.cpu_busy}, 0);
    end
    chk("stray_ack_rdata", bus.cpu_rdata, exp_rdata);
    bus.ack = 1'b0;

    bus.cpu_rd = 1'b1;
    bus.cpu_addr = 32'h30;
    tick();
    chk("midreq_stb_up", {bus.cyc, bus.stb}, 2'b11);
    tick();
    reset = 1'b1;
    tick();
    bus.cpu_rd = 1'b0;
    chk("midreq_reset_ctrl", {bus.cyc, bus.stb, bus.we, bus.cpu_done, bus.cpu_err, bus.cpu_busy}, 0);
    chk("midreq_reset_data", {bus.ADR_O, bus.DAT_O, bus.cpu_rdata}, 0);
    exp_rdata = '0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midreq_no_pulse", {bus.cyc, bus.cpu_done, bus.cpu_err}, 0);
    end

    for (int i = 0; i < 20; i++) begin
      k = $urandom_range(0, 9);
      k = (k < 4) ? 0 : ((k < 8) ? 1 : 2);
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2) : $urandom_range(0, 4);
      a = $urandom;
      d = $urandom;
      r = $urandom;
      run_txn(k, a, d, r, w, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
